// File: rtl/spi_master_ctrl_if.sv
// Bundle of the request/response handshake and the SPI pins of spi_master_ctrl.
// master is the controller's view; slave is the view of whatever drives and observes it.
interface spi_master_ctrl_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] txData;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] rxData;
  logic             CS_n;
  logic             SCLK;
  logic             MOSI;
  logic             MISO;

  modport master (
    input  start, txData, MISO,
    output busy, done, rxData, CS_n, SCLK, MOSI
  );

  modport slave (
    output start, txData, MISO,
    input  busy, done, rxData, CS_n, SCLK, MOSI
  );
endinterface

// File: rtl/spi_master_ctrl.sv
// SPI mode-0 master: one WIDTH-bit MSB-first frame per accepted start, slow explicit SCLK
// phases so a slave that synchronises SCLK/MOSI has settled MISO before it is sampled.
module spi_master_ctrl #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned CLK_DIV = 4
) (
  input logic               clk,
  input logic               rst,
  spi_master_ctrl_if.master bus
);

  localparam int unsigned CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BitW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(CLK_DIV - 1);
  localparam logic [BitW-1:0] BitLast = BitW'(WIDTH - 1);

  typedef enum logic [2:0] {StIdle, StSetup, StHigh, StLow, StHold, StGap} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [BitW-1:0]   bit_q, bit_d;
  logic [WIDTH-1:0]  tx_q, tx_d;
  logic [WIDTH-1:0]  rx_q, rx_d;
  logic [WIDTH-1:0]  rx_data_q, rx_data_d;
  logic              cs_n_q, cs_n_d;
  logic              sclk_q, sclk_d;
  logic              mosi_q, mosi_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              miso_s1_q, miso_s2_q;
  logic              phase_last;

  assign phase_last = (cnt_q == CntLast);

  // MISO is a raw pin from another clock domain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      miso_s1_q <= 1'b0;
      miso_s2_q <= 1'b0;
    end else begin
      miso_s1_q <= bus.MISO;
      miso_s2_q <= miso_s1_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      bit_q     <= '0;
      tx_q      <= '0;
      rx_q      <= '0;
      rx_data_q <= '0;
      cs_n_q    <= 1'b1;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      rx_data_q <= rx_data_d;
      cs_n_q    <= cs_n_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Pin outputs are registered from the next state, so they change in step with the FSM.
  always_comb begin
    state_d   = state_q;
    cnt_d     = phase_last ? '0 : cnt_q + 1'b1;
    bit_d     = bit_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    rx_data_d = rx_data_q;
    cs_n_d    = cs_n_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (bus.start) begin
          state_d = StSetup;
          tx_d    = bus.txData;
          bit_d   = '0;
          cs_n_d  = 1'b0;
          sclk_d  = 1'b0;
          mosi_d  = bus.txData[WIDTH-1];
          busy_d  = 1'b1;
        end
      end
      StSetup: begin
        if (phase_last) begin
          state_d = StHigh;
          sclk_d  = 1'b1;
        end
      end
      StHigh: begin
        if (phase_last) begin
          rx_d   = {rx_q[WIDTH-2:0], miso_s2_q};
          sclk_d = 1'b0;
          if (bit_q == BitLast) begin
            state_d = StHold;
          end else begin
            state_d = StLow;
            tx_d    = tx_q << 1;
            mosi_d  = tx_q[WIDTH-2];
            bit_d   = bit_q + 1'b1;
          end
        end
      end
      StLow: begin
        if (phase_last) begin
          state_d = StHigh;
          sclk_d  = 1'b1;
        end
      end
      StHold: begin
        if (phase_last) begin
          state_d = StGap;
          cs_n_d  = 1'b1;
          mosi_d  = 1'b0;
        end
      end
      StGap: begin
        if (phase_last) begin
          state_d   = StIdle;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          rx_data_d = rx_q;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.CS_n   = cs_n_q;
  assign bus.SCLK   = sclk_q;
  assign bus.MOSI   = mosi_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.rxData = rx_data_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Scoreboard bench for spi_master_ctrl: stimulus queues the expected frame, monitors check
// each frame (timing, MOSI bits, received word) when done is seen.
module tb_spi_master_ctrl;

  typedef struct packed {
    logic [15:0] tx;
    logic [15:0] rx;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   mode = 0;  // DUT0 MISO source: 0 tied high, 1 loopback, 2 echo slave
  int   n_chk = 0;
  int   n_fail = 0;

  exp_t exp0_q[$];
  exp_t exp1_q[$];

  always #5 clk = ~clk;

  spi_master_ctrl_if #(.WIDTH(8))  b0 ();
  spi_master_ctrl_if #(.WIDTH(12)) b1 ();

  spi_master_ctrl #(.WIDTH(8), .CLK_DIV(4)) dut0 (.clk(clk), .rst(rst), .bus(b0));
  spi_master_ctrl #(.WIDTH(12), .CLK_DIV(6)) dut1 (.clk(clk), .rst(rst), .bus(b1));

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- MISO sources ----------------
  logic lb0, lb1;
  always @(posedge clk) begin
    lb0 <= b0.MOSI;
    lb1 <= b1.MOSI;
  end

  // Behavioural mode-0 slave: 2-FF synchronises pins, echoes the previous frame's word.
  logic [2:0] sl_sclk, sl_cs;
  logic [1:0] sl_mosi;
  logic [7:0] sl_in, sl_out, sl_prev;
  logic       sl_miso;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      sl_sclk <= '0;
      sl_cs   <= 3'b111;
      sl_mosi <= '0;
      sl_in   <= '0;
      sl_out  <= '0;
      sl_prev <= '0;
      sl_miso <= 1'b0;
    end else begin
      sl_sclk <= {sl_sclk[1:0], b0.SCLK};
      sl_cs   <= {sl_cs[1:0], b0.CS_n};
      sl_mosi <= {sl_mosi[0], b0.MOSI};
      if (sl_cs[2] && !sl_cs[1]) begin
        sl_out  <= sl_prev;
        sl_miso <= sl_prev[7];
      end else if (!sl_cs[2] && sl_cs[1]) begin
        sl_prev <= sl_in;
      end else if (!sl_cs[1]) begin
        if (!sl_sclk[2] && sl_sclk[1]) sl_in <= {sl_in[6:0], sl_mosi[1]};
        if (sl_sclk[2] && !sl_sclk[1]) begin
          sl_out  <= {sl_out[6:0], 1'b0};
          sl_miso <= sl_out[6];
        end
      end
    end
  end

  assign b0.MISO = (mode == 0) ? 1'b1 : (mode == 1) ? lb0 : sl_miso;
  assign b1.MISO = lb1;

  // ---------------- monitor, DUT0 (WIDTH 8, CLK_DIV 4) ----------------
  int          busy_c0, rise_c0, csl_c0, gap_c0;
  logic [15:0] bits0;
  logic        pb0, pd0, ps0;
  exp_t        e0;
  always begin
    @(posedge clk);
    #1;
    if (rst) begin
      busy_c0 = 0; rise_c0 = 0; csl_c0 = 0; gap_c0 = 0; bits0 = '0;
      pb0 = 1'b0; pd0 = 1'b0; ps0 = 1'b0;
    end else begin
      if (!pb0 && b0.start) begin
        chk("accept_busy0", {31'b0, b0.busy}, 1);
        chk("accept_cs0", {31'b0, b0.CS_n}, 0);
      end
      if (b0.SCLK && !ps0) begin
        rise_c0++;
        bits0 = {bits0[14:0], b0.MOSI};
      end
      if (b0.busy) busy_c0++;
      if (!b0.CS_n) csl_c0++;
      if (b0.busy && b0.CS_n) gap_c0++;
      if (b0.done) begin
        chk("done_pulse0", {31'b0, pd0}, 0);
        chk("done_busy_low0", {31'b0, b0.busy}, 0);
        if (exp0_q.size() == 0) begin
          chk("unexpected_done0", 1, 0);
        end else begin
          e0 = exp0_q.pop_front();
          chk("busy_len0", busy_c0, 72);
          chk("sclk_rises0", rise_c0, 8);
          chk("cs_low_len0", csl_c0, 68);
          chk("cs_gap0", gap_c0, 4);
          chk("mosi_bits0", {16'b0, bits0}, {16'b0, e0.tx});
          chk("rxdata0", {24'b0, b0.rxData}, {16'b0, e0.rx});
        end
        busy_c0 = 0; rise_c0 = 0; csl_c0 = 0; gap_c0 = 0; bits0 = '0;
      end
      pb0 = b0.busy;
      pd0 = b0.done;
      ps0 = b0.SCLK;
    end
  end

  // ---------------- monitor, DUT1 (WIDTH 12, CLK_DIV 6) ----------------
  int          busy_c1, rise_c1;
  logic [15:0] bits1;
  logic        ps1;
  exp_t        e1;
  always begin
    @(posedge clk);
    #1;
    if (rst) begin
      busy_c1 = 0; rise_c1 = 0; bits1 = '0; ps1 = 1'b0;
    end else begin
      if (b1.SCLK && !ps1) begin
        rise_c1++;
        bits1 = {bits1[14:0], b1.MOSI};
      end
      if (b1.busy) busy_c1++;
      if (b1.done) begin
        if (exp1_q.size() == 0) begin
          chk("unexpected_done1", 1, 0);
        end else begin
          e1 = exp1_q.pop_front();
          chk("busy_len1", busy_c1, 156);
          chk("sclk_rises1", rise_c1, 12);
          chk("mosi_bits1", {16'b0, bits1}, {16'b0, e1.tx});
          chk("rxdata1", {20'b0, b1.rxData}, {16'b0, e1.rx});
        end
        busy_c1 = 0; rise_c1 = 0; bits1 = '0;
      end
      ps1 = b1.SCLK;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_idle0();
    int n = 0;
    while (b0.busy && n < 500) begin
      tick();
      n++;
    end
    chk("idle_timeout0", {31'b0, b0.busy}, 0);
  endtask

  task automatic wait_q0(input int depth);
    int n = 0;
    while (exp0_q.size() > depth && n < 400) begin
      tick();
      n++;
    end
    chk("done_timeout0", exp0_q.size(), depth);
    while (exp0_q.size() > depth) void'(exp0_q.pop_front());
  endtask

  task automatic frame0(input logic [7:0] tx, input logic [7:0] rx);
    exp_t e;
    wait_idle0();
    e.tx = {8'h00, tx};
    e.rx = {8'h00, rx};
    exp0_q.push_back(e);
    b0.txData = tx;
    b0.start  = 1'b1;
    tick();
    b0.start  = 1'b0;
    wait_q0(0);
  endtask

  initial begin
    exp_t e;
    int   n;
    b0.start = 1'b0; b0.txData = '0;
    b1.start = 1'b0; b1.txData = '0;
    rst = 1'b1;
    repeat (3) tick();
    chk("rst_cs_n", {31'b0, b0.CS_n}, 1);
    chk("rst_sclk", {31'b0, b0.SCLK}, 0);
    chk("rst_mosi", {31'b0, b0.MOSI}, 0);
    chk("rst_busy", {31'b0, b0.busy}, 0);
    chk("rst_done", {31'b0, b0.done}, 0);
    chk("rst_rxdata", {24'b0, b0.rxData}, 0);
    rst = 1'b0;
    tick();

    // Single frame, MISO tied high.
    mode = 0;
    frame0(8'hA5, 8'hFF);

    // Reset in cycle 20 of a frame; frame is abandoned, nothing queued for it.
    b0.txData = 8'h5A;
    b0.start  = 1'b1;
    tick();
    b0.start  = 1'b0;
    repeat (19) tick();
    chk("pre_rst_busy", {31'b0, b0.busy}, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_cs_n", {31'b0, b0.CS_n}, 1);
    chk("mid_rst_sclk", {31'b0, b0.SCLK}, 0);
    chk("mid_rst_mosi", {31'b0, b0.MOSI}, 0);
    chk("mid_rst_busy", {31'b0, b0.busy}, 0);
    chk("mid_rst_done", {31'b0, b0.done}, 0);
    chk("mid_rst_rxdata", {24'b0, b0.rxData}, 0);
    tick();
    rst = 1'b0;
    tick();

    // Loopback through a 1-cycle delay.
    mode = 1;
    frame0(8'h3C, 8'h3C);
    frame0(8'h00, 8'h00);
    frame0(8'hFF, 8'hFF);

    // Echo slave, starting from a clean slave state.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mode = 2;
    tick();
    frame0(8'h12, 8'h00);
    frame0(8'h34, 8'h12);
    frame0(8'h56, 8'h34);

    // Back-to-back with start held; txData changes mid-frame each time.
    mode = 1;
    wait_idle0();
    e.tx = 16'h0081; e.rx = 16'h0081; exp0_q.push_back(e);
    e.tx = 16'h007E; e.rx = 16'h007E; exp0_q.push_back(e);
    e.tx = 16'h00C3; e.rx = 16'h00C3; exp0_q.push_back(e);
    b0.txData = 8'h81;
    b0.start  = 1'b1;
    tick();
    b0.txData = 8'h7E;
    wait_q0(2);
    tick();
    b0.txData = 8'hC3;
    wait_q0(1);
    tick();
    b0.txData = 8'h55;
    b0.start  = 1'b0;
    wait_q0(0);

    // Parameter variant: WIDTH 12, CLK_DIV 6, loopback.
    e.tx = 16'h0ABC; e.rx = 16'h0ABC; exp1_q.push_back(e);
    b1.txData = 12'hABC;
    b1.start  = 1'b1;
    tick();
    b1.start  = 1'b0;
    n = 0;
    while (exp1_q.size() != 0 && n < 400) begin
      tick();
      n++;
    end
    chk("done_timeout1", exp1_q.size(), 0);
    repeat (4) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
